// File: rtl/cpu_bus_arbiter_if.sv
// Shared request/response memory bus between the CPU arbiter and a slave.
// master = arbiter side, slave = memory side.
interface cpu_bus_arbiter_if;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_err,
    input  bus_gnt,
    input  bus_rvalid,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_err,
    output bus_gnt,
    output bus_rvalid,
    output bus_rdata
  );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Serializes CPU data and fetch ports onto one bus, data first.
// Define ARB_TIMEOUT_EN to abort hung accesses after TIMEOUT_CYCLES.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_read,
  input  logic [31:0]       IM_addr,
  input  logic              IM_jb,
  output logic [31:0]       IM_instruction,
  output logic              AXI_IF_stall,
  input  logic              DM_read,
  input  logic [3:0]        DM_write_en,
  input  logic [31:0]       DM_addr,
  input  logic [31:0]       DM_data_write,
  output logic [31:0]       DM_data_read,
  output logic              AXI_MEM_stall,
  cpu_bus_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    DM_REQ,
    DM_WAIT,
    IF_REQ,
    IF_WAIT
  } state_e;

  state_e      state_q;
  logic        bus_req_q;
  logic [3:0]  bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] im_instr_q;
  logic [31:0] dm_rdata_q;
  logic        if_done_q;
  logic        dm_done_q;
  logic        squash_q;
  logic        win_end;
  logic        if_drop;
  logic        wd_fire;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65535");
  end

  assign AXI_MEM_stall = (DM_read | (|DM_write_en))
                       & ~dm_done_q;
  assign AXI_IF_stall  = IM_read & ~if_done_q;
  assign win_end = ~AXI_MEM_stall & ~AXI_IF_stall;
  // a redirect in the response cycle also stales it
  assign if_drop = squash_q | IM_jb;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST =
    16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q;
  logic        bus_err_q;
  assign wd_fire     = (wd_cnt_q == WD_LAST);
  assign bus.bus_err = bus_err_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  assign bus.bus_req    = bus_req_q;
  assign bus.bus_we     = bus_we_q;
  assign bus.bus_addr   = bus_addr_q;
  assign bus.bus_wdata  = bus_wdata_q;
  assign IM_instruction = im_instr_q;
  assign DM_data_read   = dm_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 4'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      im_instr_q  <= 32'd0;
      dm_rdata_q  <= 32'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      squash_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_q    <= 16'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      bus_err_q <= 1'b0;
      if (state_q == DM_WAIT || state_q == IF_WAIT)
        wd_cnt_q <= wd_cnt_q + 16'd1;
`endif
      unique case (state_q)
        IDLE: begin
          if (AXI_MEM_stall) begin
            state_q     <= DM_REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= DM_write_en;
            bus_addr_q  <= DM_addr;
            bus_wdata_q <= DM_data_write;
          end else if (AXI_IF_stall) begin
            state_q     <= IF_REQ;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 4'd0;
            bus_addr_q  <= IM_addr;
            bus_wdata_q <= 32'd0;
          end
        end
        DM_REQ: begin
          if (bus.bus_gnt) begin
            state_q   <= DM_WAIT;
            bus_req_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_q  <= 16'd1;
`endif
          end
        end
        IF_REQ: begin
          if (bus.bus_gnt) begin
            state_q   <= IF_WAIT;
            bus_req_q <= 1'b0;
            squash_q  <= IM_jb;
`ifdef ARB_TIMEOUT_EN
            wd_cnt_q  <= 16'd1;
`endif
          end
        end
        DM_WAIT: begin
          if (bus.bus_rvalid || wd_fire) begin
            state_q   <= IDLE;
            dm_done_q <= 1'b1;
            if (bus_we_q == 4'd0)
              dm_rdata_q <= bus.bus_rvalid ?
                            bus.bus_rdata : 32'd0;
`ifdef ARB_TIMEOUT_EN
            bus_err_q <= ~bus.bus_rvalid;
`endif
          end
        end
        IF_WAIT: begin
          if (bus.bus_rvalid || wd_fire) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
            if (!if_drop) begin
              im_instr_q <= bus.bus_rvalid ?
                            bus.bus_rdata : 32'd0;
              if_done_q  <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            bus_err_q <= ~bus.bus_rvalid;
`endif
          end else if (IM_jb) begin
            squash_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (win_end) begin
        if_done_q <= 1'b0;
        dm_done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed windows checked against a latency/transaction model.
// Bus slave applies per-access grant and response delays.
module tb_cpu_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        IM_read;
  logic [31:0] IM_addr;
  logic        IM_jb;
  logic [31:0] IM_instruction;
  logic        AXI_IF_stall;
  logic        DM_read;
  logic [3:0]  DM_write_en;
  logic [31:0] DM_addr;
  logic [31:0] DM_data_write;
  logic [31:0] DM_data_read;
  logic        AXI_MEM_stall;

  cpu_bus_arbiter_if bif();

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .IM_read        (IM_read),
    .IM_addr        (IM_addr),
    .IM_jb          (IM_jb),
    .IM_instruction (IM_instruction),
    .AXI_IF_stall   (AXI_IF_stall),
    .DM_read        (DM_read),
    .DM_write_en    (DM_write_en),
    .DM_addr        (DM_addr),
    .DM_data_write  (DM_data_write),
    .DM_data_read   (DM_data_read),
    .AXI_MEM_stall  (AXI_MEM_stall),
    .bus            (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h want %h",
                  nm, cyc, act, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return {a[15:0], 16'h5A3C} ^ 32'h13572468;
  endfunction

  // model state: window start, stall fall cycles, data
  bit          chk_en = 0;
  int          m_w0 = 0;
  bit          m_dm_req = 0;
  bit          m_im_req = 0;
  int          m_dm_fall = 0;
  int          m_if_fall = 0;
  logic [31:0] m_in_old = 0;
  logic [31:0] m_in_new = 0;
  logic [31:0] m_dm_old = 0;
  logic [31:0] m_dm_new = 0;

  always @(negedge clk) begin
    int rel;
    if (chk_en) begin
      rel = cyc - m_w0;
      chk("if_stall", 32'(AXI_IF_stall),
          32'(m_im_req && rel < m_if_fall));
      chk("mem_stall", 32'(AXI_MEM_stall),
          32'(m_dm_req && rel < m_dm_fall));
      chk("instr", IM_instruction,
          rel >= m_if_fall ? m_in_new : m_in_old);
      chk("dm_rdata", DM_data_read,
          rel >= m_dm_fall ? m_dm_new : m_dm_old);
      chk("bus_err", 32'(bif.bus_err), 32'd0);
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  we;
    logic [31:0] wd;
  } acc_t;

  acc_t seen_q[$];
  int   g_dly[4];
  int   r_dly[4];
  int   s_k = 0;

  initial begin
    int   ph;
    int   cnt;
    acc_t cur;
    ph = 0;
    cnt = 0;
    cur = '0;
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      bif.bus_gnt = 1'b0;
      bif.bus_rvalid = 1'b0;
      if (!rst) ph = 0;
      else case (ph)
        0: if (bif.bus_req) begin
          cur.a  = bif.bus_addr;
          cur.we = bif.bus_we;
          cur.wd = bif.bus_wdata;
          seen_q.push_back(cur);
          cnt = (s_k < 4) ? g_dly[s_k] : 0;
          if (cnt == 0) begin
            bif.bus_gnt = 1'b1;
            cnt = (s_k < 4) ? r_dly[s_k] : 0;
            ph = 2;
          end else ph = 1;
        end
        1: begin
          chk("hold_req", 32'(bif.bus_req), 32'd1);
          chk("hold_addr", bif.bus_addr, cur.a);
          chk("hold_we", 32'(bif.bus_we), 32'(cur.we));
          chk("hold_wdata", bif.bus_wdata, cur.wd);
          cnt--;
          if (cnt == 0) begin
            bif.bus_gnt = 1'b1;
            cnt = (s_k < 4) ? r_dly[s_k] : 0;
            ph = 2;
          end
        end
        default: begin
          if (cnt == 0) begin
            bif.bus_rvalid = 1'b1;
            bif.bus_rdata = mem(cur.a);
            ph = 0;
            s_k++;
          end else cnt--;
        end
      endcase
    end
  end

  // one request window; each access costs 3+grant+response cycles
  task automatic run_win(
    input bit dmr, input logic [3:0] dwe,
    input logic [31:0] da, input logic [31:0] dwd,
    input bit imr, input logic [31:0] ia,
    input int nif, input int jb_at,
    input logic [31:0] ia2,
    input int lit_dm, input int lit_if);
    int   t;
    int   k;
    bit   dreq;
    int   dfall;
    int   ifall;
    acc_t e;
    acc_t ex[$];
    t = 0;
    k = 0;
    dfall = 0;
    ifall = 0;
    dreq = dmr || (dwe != 4'd0);
    if (dreq) begin
      t += 3 + g_dly[k] + r_dly[k];
      k++;
      dfall = t;
      e.a = da;
      e.we = dwe;
      e.wd = dwd;
      ex.push_back(e);
    end
    if (imr) begin
      for (int j = 0; j < nif; j++) begin
        t += 3 + g_dly[k] + r_dly[k];
        k++;
        e.a = (j == 0) ? ia : ia2;
        e.we = 4'd0;
        e.wd = 32'd0;
        ex.push_back(e);
      end
      ifall = t;
    end
    @(posedge clk);
    #1;
    seen_q.delete();
    s_k = 0;
    m_w0 = cyc;
    m_dm_req = dreq;
    m_im_req = imr;
    m_dm_fall = dfall;
    m_if_fall = ifall;
    m_in_new = imr ? mem(nif > 1 ? ia2 : ia) : m_in_old;
    m_dm_new = (dreq && dwe == 4'd0) ? mem(da) : m_dm_old;
    chk_en = 1;
    DM_read = dmr;
    DM_write_en = dwe;
    DM_addr = da;
    DM_data_write = dwd;
    IM_read = imr;
    IM_addr = ia;
    for (int rel = 0; rel <= t; rel++) begin
      if (rel > 0) begin
        @(posedge clk);
        #1;
      end
      IM_jb = (rel == jb_at);
      if (rel == jb_at) IM_addr = ia2;
      @(negedge clk);
      if (rel == lit_dm - 1)
        chk("lit_mem_hi", 32'(AXI_MEM_stall), 32'd1);
      if (rel == lit_dm)
        chk("lit_mem_lo", 32'(AXI_MEM_stall), 32'd0);
      if (rel == lit_if - 1)
        chk("lit_if_hi", 32'(AXI_IF_stall), 32'd1);
      if (rel == lit_if)
        chk("lit_if_lo", 32'(AXI_IF_stall), 32'd0);
    end
    @(posedge clk);
    #1;
    DM_read = 1'b0;
    DM_write_en = 4'd0;
    IM_read = 1'b0;
    IM_jb = 1'b0;
    m_dm_req = 0;
    m_im_req = 0;
    m_in_old = m_in_new;
    m_dm_old = m_dm_new;
    chk("bus_acc_n", 32'(seen_q.size()), 32'(ex.size()));
    foreach (ex[i]) begin
      if (i < seen_q.size()) begin
        chk("bus_addr", seen_q[i].a, ex[i].a);
        chk("bus_we", 32'(seen_q[i].we), 32'(ex[i].we));
        if (ex[i].we != 4'd0)
          chk("bus_wdata", seen_q[i].wd, ex[i].wd);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    IM_read = 1'b0;
    IM_addr = 32'd0;
    IM_jb = 1'b0;
    DM_read = 1'b0;
    DM_write_en = 4'd0;
    DM_addr = 32'd0;
    DM_data_write = 32'd0;
    g_dly = '{0, 0, 0, 0};
    r_dly = '{0, 0, 0, 0};
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bif.bus_req), 32'd0);
    chk("rst_we", 32'(bif.bus_we), 32'd0);
    chk("rst_addr", bif.bus_addr, 32'd0);
    chk("rst_wdata", bif.bus_wdata, 32'd0);
    chk("rst_err", 32'(bif.bus_err), 32'd0);
    chk("rst_instr", IM_instruction, 32'd0);
    chk("rst_dmrd", DM_data_read, 32'd0);
    chk("rst_if_stall", 32'(AXI_IF_stall), 32'd0);
    chk("rst_mem_stall", 32'(AXI_MEM_stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    run_win(0, 4'd0, 0, 0, 1, 32'h100, 1, -1, 0, 0, 3);
    chk("lit_instr_100", IM_instruction, 32'h00500093);

    run_win(0, 4'b0011, 32'h8000, 32'hABCD,
            1, 32'h104, 1, -1, 0, 3, 6);

    g_dly[0] = 3;
    r_dly[0] = 5;
    run_win(0, 4'd0, 0, 0, 1, 32'h108, 1, -1, 0, 0, 11);

    g_dly = '{1, 0, 0, 0};
    r_dly = '{0, 2, 0, 0};
    run_win(1, 4'd0, 32'h8004, 0,
            1, 32'h10C, 1, -1, 0, 4, 9);

    g_dly = '{0, 0, 0, 0};
    r_dly = '{2, 0, 0, 0};
    run_win(0, 4'd0, 0, 0, 1, 32'h200, 2, 2, 32'h300, 0, 8);
    chk("lit_instr_300", IM_instruction, 32'h10577E54);

`ifdef ARB_TIMEOUT_EN
    chk_en = 0;
    g_dly = '{0, 0, 0, 0};
    r_dly = '{20, 0, 0, 0};
    @(posedge clk);
    #1;
    s_k = 0;
    DM_read = 1'b1;
    DM_addr = 32'h9000;
    for (int rel = 0; rel <= 12; rel++) begin
      if (rel > 0) begin
        @(posedge clk);
        #1;
      end
      if (rel == 10) DM_read = 1'b0;
      @(negedge clk);
      chk("wd_err", 32'(bif.bus_err), 32'(rel == 9));
      if (rel == 9) begin
        chk("wd_data", DM_data_read, 32'd0);
        chk("wd_stall", 32'(AXI_MEM_stall), 32'd0);
      end
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("wd_stray_rvalid", DM_data_read, 32'd0);
    m_dm_old = 32'd0;
`endif

    chk_en = 0;
    g_dly = '{0, 0, 0, 0};
    r_dly = '{20, 0, 0, 0};
    @(posedge clk);
    #1;
    s_k = 0;
    IM_read = 1'b1;
    IM_addr = 32'h500;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(bif.bus_req), 32'd0);
    chk("mid_rst_addr", bif.bus_addr, 32'd0);
    chk("mid_rst_we", 32'(bif.bus_we), 32'd0);
    chk("mid_rst_err", 32'(bif.bus_err), 32'd0);
    chk("mid_rst_instr", IM_instruction, 32'd0);
    chk("mid_rst_dmrd", DM_data_read, 32'd0);
    chk("mid_rst_if_stall", 32'(AXI_IF_stall), 32'd1);
    @(posedge clk);
    #1 IM_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    m_in_old = 32'd0;
    m_dm_old = 32'd0;
    r_dly[0] = 0;
    run_win(0, 4'd0, 0, 0, 1, 32'h400, 1, -1, 0, 0, 3);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
